// File: rtl/dyt_id_ex_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode/operand stage.
// The slave modport is the stage's view; master is the surrounding pipeline.
interface dyt_id_ex_stage_if #(
    parameter int WORD_W = 32
);
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [WORD_W-1:0] id_pc;

    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_alu_op;
    logic [WORD_W-1:0] ex_port_0;
    logic [WORD_W-1:0] ex_port_1;
    logic [4:0]        ex_rd;
    logic              ex_rd_we;
    logic [WORD_W-1:0] ex_pc;
    logic              ex_illegal;

    modport master (
        output id_valid, id_instr, id_pc, ex_ready,
        input  id_ready, ex_valid, ex_alu_op, ex_port_0, ex_port_1,
               ex_rd, ex_rd_we, ex_pc, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, id_pc, ex_ready,
        output id_ready, ex_valid, ex_alu_op, ex_port_0, ex_port_1,
               ex_rd, ex_rd_we, ex_pc, ex_illegal
    );
endinterface

// File: rtl/dyt_id_ex_stage.sv
// Decode/operand stage: owns the register file, resolves operands with forwarding
// and load-use stalls, and registers ALU op plus operands toward execute.
module dyt_id_ex_stage #(
    parameter int WORD_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    dyt_id_ex_stage_if.slave  bus,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              fwd_we,
    input  logic [4:0]        fwd_rd,
    input  logic [WORD_W-1:0] fwd_data,
    input  logic              ld_pending,
    input  logic [4:0]        ld_rd
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    logic [WORD_W-1:0] rf_q [NREGS];
    logic [WORD_W-1:0] rf_d [NREGS];

    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_alu_op_q, ex_alu_op_d;
    logic [WORD_W-1:0] ex_port_0_q, ex_port_0_d;
    logic [WORD_W-1:0] ex_port_1_q, ex_port_1_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic              ex_rd_we_q, ex_rd_we_d;
    logic [WORD_W-1:0] ex_pc_q, ex_pc_d;
    logic              ex_illegal_q, ex_illegal_d;

    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic              f7b5;
    logic [WORD_W-1:0] imm_i, imm_u;
    logic [WORD_W-1:0] rs1_val, rs2_val, opnd_b, shamt_ext;

    logic [3:0]        dec_op;
    logic [WORD_W-1:0] dec_p0, dec_p1;
    logic              dec_legal, uses_rs1, uses_rs2;
    logic              hazard, advance, id_ready, transfer;

    assign opcode = bus.id_instr[6:0];
    assign rd     = bus.id_instr[11:7];
    assign funct3 = bus.id_instr[14:12];
    assign rs1    = bus.id_instr[19:15];
    assign rs2    = bus.id_instr[24:20];
    assign f7b5   = bus.id_instr[30];
    assign imm_i  = {{(WORD_W-12){bus.id_instr[31]}}, bus.id_instr[31:20]};
    assign imm_u  = {bus.id_instr[31:12], {(WORD_W-20){1'b0}}};

    // Source priority: x0, then EX/MEM forward, then same-cycle writeback, then file.
    always_comb begin
        if (rs1 == 5'd0)                     rs1_val = '0;
        else if (fwd_we && (fwd_rd == rs1))  rs1_val = fwd_data;
        else if (wb_we && (wb_rd == rs1))    rs1_val = wb_data;
        else                                 rs1_val = rf_q[rs1];

        if (rs2 == 5'd0)                     rs2_val = '0;
        else if (fwd_we && (fwd_rd == rs2))  rs2_val = fwd_data;
        else if (wb_we && (wb_rd == rs2))    rs2_val = wb_data;
        else                                 rs2_val = rf_q[rs2];
    end

    assign opnd_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt_ext = {{(WORD_W-5){1'b0}}, opnd_b[4:0]};

    always_comb begin
        dec_op    = ALU_ADD;
        dec_p0    = '0;
        dec_p1    = '0;
        dec_legal = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                uses_rs2 = (opcode == OPC_OP);
                dec_p0   = rs1_val;
                dec_p1   = opnd_b;
                case (funct3)
                    3'b000: begin
                        if ((opcode == OPC_OP) && f7b5) begin
                            // The ALU only adds, so subtraction is fed the negated operand.
                            dec_op = ALU_SUB;
                            dec_p1 = ~opnd_b + WORD_W'(1);
                        end else begin
                            dec_op = ALU_ADD;
                        end
                    end
                    3'b001: begin
                        dec_op = ALU_SLL;
                        dec_p1 = shamt_ext;
                    end
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b101: begin
                        dec_op = f7b5 ? ALU_SRA : ALU_SRL;
                        dec_p1 = shamt_ext;
                    end
                    3'b110: dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end
            OPC_LUI: dec_p1 = imm_u;
            OPC_AUIPC: begin
                dec_p0 = bus.id_pc;
                dec_p1 = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign hazard = ld_pending && (ld_rd != 5'd0) &&
                    ((uses_rs1 && (ld_rd == rs1)) || (uses_rs2 && (ld_rd == rs2)));
    assign advance = ~ex_valid_q | bus.ex_ready;

    always_comb begin
        if (rst)        id_ready = 1'b0;
        else if (flush) id_ready = 1'b1;
        else            id_ready = advance & ~hazard;
    end

    assign transfer = bus.id_valid & id_ready & ~flush;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_port_0_d  = ex_port_0_q;
        ex_port_1_d  = ex_port_1_q;
        ex_rd_d      = ex_rd_q;
        ex_rd_we_d   = ex_rd_we_q;
        ex_pc_d      = ex_pc_q;
        ex_illegal_d = ex_illegal_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (transfer) begin
            ex_valid_d   = 1'b1;
            ex_alu_op_d  = dec_op;
            ex_port_0_d  = dec_p0;
            ex_port_1_d  = dec_p1;
            ex_rd_d      = rd;
            ex_rd_we_d   = dec_legal && (rd != 5'd0);
            ex_pc_d      = bus.id_pc;
            ex_illegal_d = ~dec_legal;
        end else if (advance) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_rd != 5'd0)) rf_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_alu_op_q  <= '0;
            ex_port_0_q  <= '0;
            ex_port_1_q  <= '0;
            ex_rd_q      <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_port_0_q  <= ex_port_0_d;
            ex_port_1_q  <= ex_port_1_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_we_q   <= ex_rd_we_d;
            ex_pc_q      <= ex_pc_d;
            ex_illegal_q <= ex_illegal_d;
            rf_q         <= rf_d;
        end
    end

    assign bus.id_ready   = id_ready;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_alu_op  = ex_alu_op_q;
    assign bus.ex_port_0  = ex_port_0_q;
    assign bus.ex_port_1  = ex_port_1_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_rd_we   = ex_rd_we_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_illegal = ex_illegal_q;
endmodule

// File: tb/tb_dyt_id_ex_stage.sv
// Bench for dyt_id_ex_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_dyt_id_ex_stage;
    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
    localparam logic [3:0] A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;

    logic clk = 1'b0;
    logic rst, flush, wb_we, fwd_we, ld_pending;
    logic [4:0] wb_rd, fwd_rd, ld_rd;
    logic [31:0] wb_data, fwd_data;

    dyt_id_ex_stage_if #(.WORD_W(32)) bus ();

    dyt_id_ex_stage #(.WORD_W(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .ld_pending(ld_pending), .ld_rd(ld_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [31:0] mreg [32];
    bit          m_known = 0;
    bit          m_valid = 0;
    logic [3:0]  m_op;
    logic [31:0] m_p0, m_p1, m_pc;
    logic [4:0]  m_rd;
    bit          m_rdwe, m_ill;
    // Pending next state
    bit          n_rst, n_valid, n_load, n_wr;
    logic [3:0]  n_op;
    logic [31:0] n_p0, n_p1, n_pc, n_wr_data;
    logic [4:0]  n_rd, n_wr_rd;
    bit          n_rdwe, n_ill;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mval(input logic [4:0] rs);
        if (rs == 0) return 32'd0;
        if (fwd_we && fwd_rd == rs) return fwd_data;
        if (wb_we && wb_rd == rs) return wb_data;
        return mreg[rs];
    endfunction

    function automatic void mdecode(input logic [31:0] ins, input logic [31:0] pc,
                                    output logic [3:0] op, output logic [31:0] p0, p1,
                                    output bit legal, u1, u2);
        logic [6:0] opc;
        logic [31:0] a, b;
        opc = ins[6:0];
        a = mval(ins[19:15]);
        b = (opc == OP) ? mval(ins[24:20]) : 32'($signed(ins[31:20]));
        op = A_ADD; p0 = 0; p1 = 0; legal = 1; u1 = 0; u2 = 0;
        if (opc == OP || opc == OPIMM) begin
            u1 = 1; u2 = (opc == OP); p0 = a; p1 = b;
            case (ins[14:12])
                0: if (opc == OP && ins[30]) begin op = A_SUB; p1 = 32'd0 - b; end
                1: begin op = A_SLL; p1 = b % 32; end
                2: op = A_SLT;
                3: op = A_SLTU;
                4: op = A_XOR;
                5: begin op = ins[30] ? A_SRA : A_SRL; p1 = b % 32; end
                6: op = A_OR;
                default: op = A_AND;
            endcase
        end else if (opc == LUI) begin
            p1 = ins & 32'hFFFFF000;
        end else if (opc == AUIPC) begin
            p0 = pc; p1 = ins & 32'hFFFFF000;
        end else begin
            legal = 0;
        end
    endfunction

    function automatic bit m_ready();
        logic [3:0] op; logic [31:0] p0, p1; bit legal, u1, u2, hz;
        if (rst) return 0;
        if (flush) return 1;
        mdecode(bus.id_instr, bus.id_pc, op, p0, p1, legal, u1, u2);
        hz = ld_pending && ld_rd != 0 &&
             ((u1 && ld_rd == bus.id_instr[19:15]) || (u2 && ld_rd == bus.id_instr[24:20]));
        return (!m_valid || bus.ex_ready) && !hz;
    endfunction

    task automatic compare_all();
        check("id_ready", {31'd0, bus.id_ready}, {31'd0, m_ready()});
        if (!m_known) return;
        check("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("ex_alu_op", {28'd0, bus.ex_alu_op}, {28'd0, m_op});
            check("ex_port_0", bus.ex_port_0, m_p0);
            check("ex_port_1", bus.ex_port_1, m_p1);
            check("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m_rd});
            check("ex_rd_we", {31'd0, bus.ex_rd_we}, {31'd0, m_rdwe});
            check("ex_pc", bus.ex_pc, m_pc);
            check("ex_illegal", {31'd0, bus.ex_illegal}, {31'd0, m_ill});
        end
    endtask

    task automatic model_next();
        bit legal, u1, u2, rdy;
        rdy = m_ready();
        n_rst = rst; n_load = 0; n_valid = m_valid;
        n_wr = !rst && wb_we && wb_rd != 0; n_wr_rd = wb_rd; n_wr_data = wb_data;
        if (!rst) begin
            if (flush) n_valid = 0;
            else if (bus.id_valid && rdy) begin
                n_load = 1; n_valid = 1;
                mdecode(bus.id_instr, bus.id_pc, n_op, n_p0, n_p1, legal, u1, u2);
                n_rd = bus.id_instr[11:7]; n_rdwe = legal && n_rd != 0;
                n_pc = bus.id_pc; n_ill = !legal;
            end else if (!m_valid || bus.ex_ready) n_valid = 0;
        end
    endtask

    task automatic commit();
        if (n_rst) begin
            m_known = 1; m_valid = 0; m_op = 0; m_p0 = 0; m_p1 = 0; m_pc = 0;
            m_rd = 0; m_rdwe = 0; m_ill = 0;
            for (int i = 0; i < 32; i++) mreg[i] = 0;
        end else begin
            m_valid = n_valid;
            if (n_load) begin
                m_op = n_op; m_p0 = n_p0; m_p1 = n_p1; m_rd = n_rd;
                m_rdwe = n_rdwe; m_pc = n_pc; m_ill = n_ill;
            end
            if (n_wr) mreg[n_wr_rd] = n_wr_data;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        model_next();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic idle();
        rst = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        fwd_we = 0; fwd_rd = 0; fwd_data = 0; ld_pending = 0; ld_rd = 0;
        bus.id_valid = 0; bus.id_instr = 0; bus.id_pc = 0; bus.ex_ready = 1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: return enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, b, a, 3'($urandom), d, OP);
            1: return enc_i(12'($urandom), a, 3'($urandom), d, OPIMM);
            2: return {20'($urandom), d, LUI};
            3: return {20'($urandom), d, AUIPC};
            4: return enc_i(12'($urandom), a, 3'b010, d, 7'b0000011);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        check("id_ready_in_rst", {31'd0, bus.id_ready}, 32'd0);
        step();
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_port_0", bus.ex_port_0, 32'd0);
        check("rst_alu_op", {28'd0, bus.ex_alu_op}, 32'd0);
        idle();

        wb_we = 1; wb_rd = 5; wb_data = 7; step();
        wb_rd = 6; wb_data = 3; step();
        idle();
        bus.id_valid = 1; bus.id_instr = enc_r(7'h20, 6, 5, 0, 7, OP); step();
        check("sub_op", {28'd0, bus.ex_alu_op}, {28'd0, A_SUB});
        check("sub_p0", bus.ex_port_0, 32'd7);
        check("sub_p1", bus.ex_port_1, 32'hFFFFFFFD);
        check("sub_rd", {27'd0, bus.ex_rd}, 32'd7);
        check("sub_rdwe", {31'd0, bus.ex_rd_we}, 32'd1);

        idle(); wb_we = 1; wb_rd = 2; wb_data = 32'h80000000; step();
        idle(); bus.id_valid = 1; bus.id_instr = enc_i(12'h424, 2, 5, 1, OPIMM); step();
        check("srai_op", {28'd0, bus.ex_alu_op}, {28'd0, A_SRA});
        check("srai_p0", bus.ex_port_0, 32'h80000000);
        check("srai_p1", bus.ex_port_1, 32'd4);
        bus.id_instr = enc_r(7'h20, 2, 0, 0, 3, OP); step();
        check("sub_min_p1", bus.ex_port_1, 32'h80000000);

        bus.id_instr = enc_r(7'h00, 0, 5, 0, 1, OP);
        fwd_we = 1; fwd_rd = 5; fwd_data = 32'h11;
        wb_we = 1; wb_rd = 5; wb_data = 32'h22; step();
        check("fwd_wins", bus.ex_port_0, 32'h11);
        fwd_we = 0; step();
        check("wb_bypass", bus.ex_port_0, 32'h22);
        wb_we = 0; bus.id_instr = enc_i(12'd1, 1, 0, 0, OPIMM); step();
        check("x0_rdwe", {31'd0, bus.ex_rd_we}, 32'd0);

        ld_pending = 1; ld_rd = 3; bus.id_instr = enc_r(7'h00, 1, 3, 6, 4, OP); #1;
        check("hazard_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        check("hazard_bubble", {31'd0, bus.ex_valid}, 32'd0);
        ld_pending = 0; step();
        check("hazard_release", {31'd0, bus.ex_valid}, 32'd1);
        check("hazard_rd", {27'd0, bus.ex_rd}, 32'd4);
        ld_pending = 1; bus.id_instr = {20'h00001, 5'd4, LUI}; #1;
        check("lui_no_stall", {31'd0, bus.id_ready}, 32'd1);
        step();

        ld_pending = 0; bus.ex_ready = 0; bus.id_instr = enc_i(12'd5, 0, 0, 9, OPIMM); #1;
        check("stall_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        check("stall_hold_p1", bus.ex_port_1, 32'h00001000);
        check("stall_hold_rd", {27'd0, bus.ex_rd}, 32'd4);
        flush = 1; #1;
        check("flush_ready", {31'd0, bus.id_ready}, 32'd1);
        step();
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        flush = 0; bus.id_valid = 0; step();
        check("flush_dropped", {31'd0, bus.ex_valid}, 32'd0);

        bus.ex_ready = 1; bus.id_valid = 1; bus.id_instr = 32'h00002083; step();
        check("illegal", {31'd0, bus.ex_illegal}, 32'd1);
        check("illegal_rdwe", {31'd0, bus.ex_rd_we}, 32'd0);
        bus.id_instr = {20'h12345, 5'd1, AUIPC}; bus.id_pc = 32'h100; step();
        check("auipc_p0", bus.ex_port_0, 32'h100);
        check("auipc_p1", bus.ex_port_1, 32'h12345000);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 29) == 0);
            wb_we = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            fwd_we = ($urandom_range(0, 3) == 0); fwd_rd = 5'($urandom_range(0, 7));
            fwd_data = $urandom;
            ld_pending = ($urandom_range(0, 3) == 0); ld_rd = 5'($urandom_range(0, 7));
            bus.id_valid = ($urandom_range(0, 4) != 0);
            bus.id_instr = rand_instr(); bus.id_pc = $urandom;
            bus.ex_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dyt_id_ex_stage.md
# dyt_id_ex_stage

Decode/operand stage that sits directly upstream of the execute ALU. It accepts one instruction per cycle from fetch and owns the 32×32 integer register file. It resolves source operands through forwarding and stall logic, translates the instruction into an ALU opcode plus two operand words, and presents them to execute through a registered valid/ready handshake.

## Interface
Parameters:
- WORD_W, 32, datapath width; equals common_types WORD_W
- NREGS, 32, architectural registers; x0 is hardwired to 0

Ports:
- clk  in  1  stage clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  fetch presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_instr  in  32  RV32I instruction word
- id_pc  in  WORD_W  PC of id_instr
- flush  in  1  kill the held and incoming instruction
- wb_we, wb_rd, wb_data  in  1/5/WORD_W  writeback port into the register file
- fwd_we, fwd_rd, fwd_data  in  1/5/WORD_W  EX/MEM result available for forwarding
- ld_pending, ld_rd  in  1/5  a load in EX/MEM whose data is not yet available
- ex_valid  out  1  registered instruction is valid for execute
- ex_ready  in  1  execute consumes the instruction
- ex_alu_op  out  aluop_t  ALU operation
- ex_port_0, ex_port_1  out  WORD_W  ALU operands
- ex_rd, ex_rd_we  out  5/1  destination register and write enable
- ex_pc  out  WORD_W  passthrough PC
- ex_illegal  out  1  unsupported opcode

## Operation
- Supported opcodes: OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111). Any other opcode sets ex_illegal=1, alu_op=ALU_ADD, ports=0, rd_we=0.
- OP/OP-IMM funct3 mapping: 000 gives ADD, or SUB when OP and funct7[5]=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (funct7[5]), 110 OR, 111 AND.
- ALU_SUB contract: the ALU adds its ports, so port_1 = ~rs2 + 1 (two's complement, modulo 2^WORD_W). This holds for the most-negative value too.
- Shift operands: the ALU shifts by the full port_1, so port_1 = {27'b0, shamt[4:0]}. The source is rs2[4:0] for OP and instr[24:20] for OP-IMM.
- I-immediate is sign-extended instr[31:20]. LUI gives port_0=0, port_1={instr[31:12],12'b0}, ADD. AUIPC gives port_0=id_pc with the same port_1, ADD.
- rd_we = (rd != 0) & legal.
- Operand resolution priority per source:
  - rs==0 resolves to 0.
  - fwd_we & fwd_rd==rs resolves to fwd_data.
  - wb_we & wb_rd==rs resolves to wb_data (write-through bypass).
  - Otherwise the register file value.
- Register file: write on wb_we & wb_rd!=0 at the clock edge. Writes to x0 are ignored.
- Load-use hazard: ld_pending & ld_rd!=0 & ld_rd matches a source the instruction actually uses. rs1 is used by OP/OP-IMM; rs2 only by OP.
- On a hazard: id_ready=0. A bubble (ex_valid=0) is inserted when the output register advances.

## Timing
- Reset (one rst cycle): ex_valid=0, all ex_* outputs 0, all registers 0. id_ready=0 while rst=1.
- advance = ~ex_valid | ex_ready.
- id_ready = advance & ~hazard & ~rst.
- Transfer occurs when id_valid & id_ready; outputs update at the next edge. Latency is 1 cycle.
- When advance & ~transfer, ex_valid becomes 0 at the next edge.
- While ex_valid & ~ex_ready, all ex_* outputs hold stable. Operands are captured at transfer and never recomputed.
- flush has priority over everything except rst:
  - ex_valid becomes 0 at the next edge.
  - id_ready=1, and the incoming instruction is discarded.
  - The register file is still written by wb.
- Simultaneous wb and fwd to the same register: fwd wins.
- A wb write in the same cycle as a read returns the new value.
- rst asserted mid-stall clears state regardless of ex_ready.

## Test plan
- After rst, wb writes x5=7 and x6=3. Then `sub x7,x5,x6` -> ex_alu_op=ALU_SUB, port_0=7, port_1=0xFFFFFFFD, ex_rd=7, ex_rd_we=1, one cycle after transfer.
- `srai x1,x2,36` encoding with instr[24:20]=4, x2=0x80000000 -> ALU_SRA, port_1=4. `sub` with rs2=0x80000000 -> port_1=0x80000000.
- fwd_we/rd=5/data=0x11 and wb_we/rd=5/data=0x22 in the same cycle as `add x1,x5,x0` -> port_0=0x11. With fwd_we=0 -> port_0=0x22. `addi x0,...` -> ex_rd_we=0.
- ld_pending=1, ld_rd=3, id_instr=`or x4,x3,x1` -> id_ready=0 and next ex_valid=0. The instruction is accepted once ld_pending=0. `lui x4,...` under the same hazard is not stalled.
- ex_ready=0 for 3 cycles while ex_valid=1 -> outputs stable and id_ready=0. flush in cycle 2 -> ex_valid=0 next edge, and the incoming instruction is dropped.
- id_instr opcode 0000011 -> ex_illegal=1, ex_rd_we=0. `auipc x1,0x12345` with pc=0x100 -> port_0=0x100, port_1=0x12345000.
